// File: rtl/ft245_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ft245_pkg
// Brief    : FT245 strobe timing constants, ns-to-cycle helper, FSM types
// Revision : 1.0
// ============================================================================
package ft245_pkg;

  localparam int T_ACT_NS = 60;
  localparam int T_PRE_NS = 80;
  localparam int T_SET_NS = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACT  = 3'd1,
    RD_PRE  = 3'd2,
    WR_SET  = 3'd3,
    WR_ACT  = 3'd4,
    WR_HOLD = 3'd5,
    WR_PRE  = 3'd6
  } ft245_state_e;

  typedef enum logic {
    LAST_RX = 1'b0,
    LAST_TX = 1'b1
  } ft245_dir_e;

  // Integer ceil(ns / period); period given in ps so no real math is needed here.
  function automatic int ns_to_cycles(input int ns, input int period_ps);
    int n;
    n = (ns * 1000 + period_ps - 1) / period_ps;
    return (n < 1) ? 1 : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous level input
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ft245_interface_core.sv
`default_nettype none
// ============================================================================
// Module   : ft245_interface_core
// Brief    : FT245 async FIFO RD#/WR strobe controller with ready/ack streams
// Revision : 1.0
// ============================================================================
module ft245_interface_core
  import ft245_pkg::*;
#(
  parameter int  FT245_DATA_WIDTH = 8,
  parameter int  RX_WIDTH         = 8,
  parameter int  TX_WIDTH         = 8,
  parameter real CLOCK_PERIOD_NS  = 10.0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FT245_DATA_WIDTH-1:0] rx_data_245,
  input  logic                        rxf_245,
  output logic                        rx_245,
  output logic [FT245_DATA_WIDTH-1:0] tx_data_245,
  input  logic                        txe_245,
  output logic                        wr_245,
  output logic                        tx_oe_245,
  output logic [RX_WIDTH-1:0]         rx_data_si,
  output logic                        rx_rdy_si,
  input  logic                        rx_ack_si,
  input  logic [TX_WIDTH-1:0]         tx_data_si,
  input  logic                        tx_rdy_si,
  output logic                        tx_ack_si
);

  localparam int c_period_ps = $rtoi(CLOCK_PERIOD_NS * 1000.0 + 0.5);
  localparam int c_act       = ns_to_cycles(T_ACT_NS, c_period_ps);
  localparam int c_pre       = ns_to_cycles(T_PRE_NS, c_period_ps);
  localparam int c_set       = ns_to_cycles(T_SET_NS, c_period_ps);
  localparam int c_cnt_max   = (c_act > c_pre) ? ((c_act > c_set) ? c_act : c_set)
                                               : ((c_pre > c_set) ? c_pre : c_set);
  localparam int c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_act_ld = c_cnt_w'(c_act - 1);
  localparam logic [c_cnt_w-1:0] c_pre_ld = c_cnt_w'(c_pre - 1);
  localparam logic [c_cnt_w-1:0] c_set_ld = c_cnt_w'(c_set - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  logic w_rxf_s;
  logic w_txe_s;
  logic w_rd_req;
  logic w_wr_req;

  ft245_state_e                r_state;
  ft245_dir_e                  r_last;
  logic [c_cnt_w-1:0]          r_cnt;
  logic                        r_rx_n;
  logic                        r_wr;
  logic                        r_oe;
  logic [FT245_DATA_WIDTH-1:0] r_tx_data;
  logic [RX_WIDTH-1:0]         r_rx_data;
  logic                        r_rx_rdy;
  logic                        r_tx_ack;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxf_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxf_245),
    .o_q (w_rxf_s)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_txe_sync (
    .clk (clk),
    .rst (rst),
    .i_d (txe_245),
    .o_q (w_txe_s)
  );

  // A read is only started when the one-entry rx buffer is free.
  assign w_rd_req = !w_rxf_s && !r_rx_rdy;
  assign w_wr_req = !w_txe_s && tx_rdy_si;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= LAST_TX;
      r_cnt     <= '0;
      r_rx_n    <= 1'b1;
      r_wr      <= 1'b0;
      r_oe      <= 1'b0;
      r_tx_data <= '0;
      r_rx_data <= '0;
      r_rx_rdy  <= 1'b0;
      r_tx_ack  <= 1'b0;
    end else begin
      r_tx_ack <= 1'b0;
      if (rx_ack_si && r_rx_rdy) begin
        r_rx_rdy <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          // When both sides want the bus, the side not served last time wins.
          if (w_rd_req && (!w_wr_req || (r_last == LAST_TX))) begin
            r_state <= RD_ACT;
            r_rx_n  <= 1'b0;
            r_cnt   <= c_act_ld;
          end else if (w_wr_req) begin
            r_state   <= WR_SET;
            r_tx_data <= FT245_DATA_WIDTH'(tx_data_si);
            r_oe      <= 1'b1;
            r_tx_ack  <= 1'b1;
            r_cnt     <= c_set_ld;
          end
        end

        RD_ACT: begin
          if (r_cnt == '0) begin
            r_state   <= RD_PRE;
            r_rx_n    <= 1'b1;
            r_rx_data <= RX_WIDTH'(rx_data_245);
            r_rx_rdy  <= 1'b1;
            r_cnt     <= c_pre_ld;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        RD_PRE: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_last  <= LAST_RX;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        WR_SET: begin
          if (r_cnt == '0) begin
            r_state <= WR_ACT;
            r_wr    <= 1'b1;
            r_cnt   <= c_act_ld;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        WR_ACT: begin
          if (r_cnt == '0) begin
            r_state <= WR_HOLD;
            r_wr    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        WR_HOLD: begin
          r_state <= WR_PRE;
          r_oe    <= 1'b0;
          r_cnt   <= c_pre_ld;
        end

        WR_PRE: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_last  <= LAST_TX;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        default: begin
          r_state <= IDLE;
          r_rx_n  <= 1'b1;
          r_wr    <= 1'b0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign rx_245      = r_rx_n;
  assign wr_245      = r_wr;
  assign tx_oe_245   = r_oe;
  assign tx_data_245 = r_tx_data;
  assign rx_data_si  = r_rx_data;
  assign rx_rdy_si   = r_rx_rdy;
  assign tx_ack_si   = r_tx_ack;

endmodule
`default_nettype wire

// File: tb/tb_ft245_interface_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_interface_core
// Brief    : Randomized self-checking bench with FT245 chip/stream models
// Revision : 1.0
// ============================================================================
module tb_ft245_interface_core;

  localparam int c_period_ns = 10;
  localparam int C_ACT       = (60 + c_period_ns - 1) / c_period_ns;
  localparam int C_PRE       = (80 + c_period_ns - 1) / c_period_ns;
  localparam int C_SET       = (20 + c_period_ns - 1) / c_period_ns;
  localparam int C_RD_TOT    = C_ACT + C_PRE;
  localparam int C_WR_TOT    = C_SET + C_ACT + 1 + C_PRE;
  localparam int SEL_RD      = 0;
  localparam int SEL_WR      = 1;
  localparam int SEL_ACK     = 2;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data_245;
  logic       rxf_245;
  logic       rx_245;
  logic [7:0] tx_data_245;
  logic       txe_245;
  logic       wr_245;
  logic       tx_oe_245;
  logic [7:0] rx_data_si;
  logic       rx_rdy_si;
  logic       rx_ack_si;
  logic [7:0] tx_data_si;
  logic       tx_rdy_si;
  logic       tx_ack_si;

  ft245_interface_core #(
    .FT245_DATA_WIDTH (8),
    .RX_WIDTH         (8),
    .TX_WIDTH         (8),
    .CLOCK_PERIOD_NS  (10.0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data_245 (rx_data_245),
    .rxf_245     (rxf_245),
    .rx_245      (rx_245),
    .tx_data_245 (tx_data_245),
    .txe_245     (txe_245),
    .wr_245      (wr_245),
    .tx_oe_245   (tx_oe_245),
    .rx_data_si  (rx_data_si),
    .rx_rdy_si   (rx_rdy_si),
    .rx_ack_si   (rx_ack_si),
    .tx_data_si  (tx_data_si),
    .tx_rdy_si   (tx_rdy_si),
    .tx_ack_si   (tx_ack_si)
  );

  initial clk = 1'b0;
  always #(c_period_ns / 2) clk = ~clk;

  // Chip rx FIFO, bytes delivered to the consumer, tx source, bytes handed to the chip.
  logic [7:0] chip_q[$];
  logic [7:0] cons_q[$];
  logic [7:0] src_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] log_q[$];
  int         log_cyc[$];

  int   n_cmp;
  int   n_err;
  int   cyc;
  logic mon_en;
  logic chip_en;
  logic src_en;
  logic hs;
  logic prev_rx;
  logic prev_wr;
  logic prev_ack;
  logic hold_chk;
  int   rd_len;
  int   wr_len;
  int   oe_len;
  int   rd_count;
  int   wr_rise;
  int   ack_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic init_mon();
    prev_rx  = 1'b1;
    prev_wr  = 1'b0;
    prev_ack = 1'b0;
    hold_chk = 1'b0;
    hs       = 1'b0;
    rd_len   = 0;
    wr_len   = 0;
    oe_len   = 0;
  endtask

  task automatic drive();
    rxf_245     = !(chip_en && (chip_q.size() > 0));
    rx_data_245 = 8'h00;
    if (chip_q.size() > 0) rx_data_245 = chip_q[0];
    tx_rdy_si   = src_en && (src_q.size() > 0);
    tx_data_si  = 8'h00;
    if (src_q.size() > 0) tx_data_si = src_q[0];
  endtask

  task automatic observe();
    // Consumer handshake seen at the previous edge must have emptied the buffer.
    if (hs) begin
      chk("rx_rdy_clear", rx_rdy_si, 1'b0);
      if (cons_q.size() > 0) void'(cons_q.pop_front());
    end

    if (rx_245 == 1'b0) begin
      chk("rd_excl", {wr_245, tx_oe_245}, 2'b00);
      if (prev_rx) begin
        rd_count++;
        log_q.push_back(8'h52);
        log_cyc.push_back(cyc);
      end
      rd_len++;
    end else if (!prev_rx) begin
      chk("rd_len", rd_len, C_ACT);
      chk("rd_rdy", rx_rdy_si, 1'b1);
      if (chip_q.size() > 0) begin
        chk("rd_data", rx_data_si, chip_q[0]);
        cons_q.push_back(chip_q.pop_front());
      end else begin
        chk("rd_underflow", rx_245, 1'b0);
      end
      rd_len = 0;
    end

    if (rx_rdy_si) begin
      if (cons_q.size() > 0) chk("rx_hold", rx_data_si, cons_q[0]);
      else chk("rx_spurious", rx_rdy_si, 1'b0);
    end

    if (tx_ack_si) begin
      chk("ack_pulse", prev_ack, 1'b0);
      chk("ack_oe", {tx_oe_245, wr_245}, 2'b10);
      ack_count++;
      log_q.push_back(8'h57);
      log_cyc.push_back(cyc);
      if (src_q.size() > 0) begin
        chk("ack_data", tx_data_245, src_q[0]);
        sent_q.push_back(src_q.pop_front());
      end else begin
        chk("ack_spurious", tx_ack_si, 1'b0);
      end
    end

    if (hold_chk) begin
      chk("oe_release", tx_oe_245, 1'b0);
      hold_chk = 1'b0;
    end

    if (wr_245) begin
      if (!prev_wr) begin
        chk("wr_setup", oe_len, C_SET);
        wr_rise++;
        if (sent_q.size() > 0) chk("wr_data", tx_data_245, sent_q[0]);
        else chk("wr_spurious", wr_245, 1'b0);
      end
      chk("wr_oe", tx_oe_245, 1'b1);
      wr_len++;
    end else if (prev_wr) begin
      chk("wr_len", wr_len, C_ACT);
      chk("wr_hold_oe", tx_oe_245, 1'b1);
      if (sent_q.size() > 0) begin
        chk("wr_hold_data", tx_data_245, sent_q[0]);
        void'(sent_q.pop_front());
      end
      hold_chk = 1'b1;
      wr_len   = 0;
    end

    oe_len   = tx_oe_245 ? oe_len + 1 : 0;
    prev_rx  = rx_245;
    prev_wr  = wr_245;
    prev_ack = tx_ack_si;
  endtask

  task automatic cycle();
    hs = rx_rdy_si && rx_ack_si;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mon_en) observe();
    drive();
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      SEL_RD:  return (rx_245 == 1'b0);
      SEL_WR:  return wr_245;
      SEL_ACK: return tx_ack_si;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit);
    int n;
    n = 0;
    while (!cond(sel) && (n < limit)) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int t0;
    int a0;
    n_cmp = 0; n_err = 0; cyc = 0;
    rd_count = 0; wr_rise = 0; ack_count = 0;
    mon_en = 1'b0; chip_en = 1'b1; src_en = 1'b1;
    rst = 1'b1; txe_245 = 1'b1; rx_ack_si = 1'b0;
    init_mon();
    drive();

    // Reset
    repeat (3) cycle();
    chk("rst_rx_n", rx_245, 1'b1);
    chk("rst_wr", wr_245, 1'b0);
    chk("rst_oe", tx_oe_245, 1'b0);
    chk("rst_rdy", rx_rdy_si, 1'b0);
    chk("rst_ack", tx_ack_si, 1'b0);
    chk("rst_rx_data", rx_data_si, 8'h00);
    chk("rst_tx_data", tx_data_245, 8'h00);
    rst = 1'b0;
    init_mon();
    mon_en = 1'b1;
    repeat (2) cycle();

    // Single read; buffer stays full while rxf remains low
    chip_q.push_back(8'hA5);
    chip_q.push_back(8'($urandom));
    drive();
    t0 = cyc;
    wait_for(SEL_RD, 10);
    chk("rd_start", rx_245, 1'b0);
    chk("rd_latency", cyc - t0, 3);
    repeat (30) cycle();
    chk("rd_once", rd_count, 1);
    chk("rd_buf_rdy", rx_rdy_si, 1'b1);
    chk("rd_buf_data", rx_data_si, 8'hA5);
    rx_ack_si = 1'b1;
    t0 = cyc;
    cycle();
    rx_ack_si = 1'b0;
    wait_for(SEL_RD, 10);
    chk("rd2_start", rx_245, 1'b0);
    chk("rd2_latency", cyc - t0, 2);
    rx_ack_si = 1'b1;
    repeat (25) cycle();

    // Flow control, then single write of 8'h3C
    src_q.push_back(8'h3C);
    drive();
    repeat (20) cycle();
    chk("flow_no_ack", ack_count, 0);
    chk("flow_no_wr", wr_rise, 0);
    txe_245 = 1'b0;
    t0 = cyc;
    wait_for(SEL_ACK, 10);
    chk("wr_ack_seen", tx_ack_si, 1'b1);
    chk("wr_latency", cyc - t0, 3);
    repeat (25) cycle();
    chk("wr_done", wr_rise, 1);

    // Arbitration: both sides pending continuously
    txe_245 = 1'b1;
    repeat (5) cycle();
    for (int i = 0; i < 6; i++) begin
      chip_q.push_back(8'($urandom));
      src_q.push_back(8'($urandom));
    end
    a0 = log_q.size();
    txe_245 = 1'b0;
    drive();
    t0 = 0;
    while ((log_q.size() < a0 + 8) && (t0 < 300)) begin
      cycle();
      t0++;
    end
    if (log_q.size() >= a0 + 8) begin
      chk("arb_first", log_q[a0], 8'h52);
      for (int i = 1; i < 8; i++) begin
        chk("arb_alt", (log_q[a0 + i] != log_q[a0 + i - 1]) ? 1 : 0, 1);
        chk("arb_gap", log_cyc[a0 + i] - log_cyc[a0 + i - 1],
            (log_q[a0 + i - 1] == 8'h52) ? C_RD_TOT + 1 : C_WR_TOT + 1);
      end
    end else begin
      chk("arb_count", log_q.size(), a0 + 8);
    end
    txe_245 = 1'b1;
    chip_en = 1'b0;
    drive();
    repeat (40) cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ((chip_q.size() < 4) && ($urandom_range(7) == 0)) chip_q.push_back(8'($urandom));
      if ((src_q.size() < 4) && ($urandom_range(7) == 0)) src_q.push_back(8'($urandom));
      chip_en   = ($urandom_range(3) != 0);
      src_en    = ($urandom_range(3) != 0);
      rx_ack_si = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) txe_245 = ~txe_245;
      drive();
      cycle();
    end

    // Drain everything still queued
    chip_en = 1'b1; src_en = 1'b1; txe_245 = 1'b0; rx_ack_si = 1'b1;
    drive();
    t0 = 0;
    while (((chip_q.size() + src_q.size() + sent_q.size() + cons_q.size()) != 0) && (t0 < 3000)) begin
      cycle();
      t0++;
    end
    repeat (30) cycle();
    chk("drain_chip", chip_q.size(), 0);
    chk("drain_tx", src_q.size() + sent_q.size(), 0);
    chk("drain_cons", cons_q.size(), 0);

    // Reset in the middle of WR_ACT
    src_q.push_back(8'($urandom));
    drive();
    wait_for(SEL_WR, 40);
    chk("rstw_wr_seen", wr_245, 1'b1);
    cycle();
    rst = 1'b1;
    mon_en = 1'b0;
    cycle();
    chk("rstw_wr", wr_245, 1'b0);
    chk("rstw_oe", tx_oe_245, 1'b0);
    chk("rstw_rx_n", rx_245, 1'b1);
    chk("rstw_ack", tx_ack_si, 1'b0);
    chk("rstw_rdy", rx_rdy_si, 1'b0);
    rst = 1'b0;
    chip_q.delete(); cons_q.delete(); src_q.delete(); sent_q.delete();
    txe_245 = 1'b1;
    init_mon();
    mon_en = 1'b1;
    drive();
    repeat (3) cycle();

    // After reset the FSM must be idle: a read starts with the nominal latency
    chip_q.push_back(8'h5A);
    rx_ack_si = 1'b1;
    drive();
    t0 = cyc;
    wait_for(SEL_RD, 10);
    chk("post_rst_rd", rx_245, 1'b0);
    chk("post_rst_latency", cyc - t0, 3);
    repeat (20) cycle();
    chk("post_rst_drain", chip_q.size() + cons_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ft245_interface_core.md
# ft245_interface_core

Clocked controller for an FTDI FT245-style asynchronous parallel FIFO. It converts the chip's RXF#/RD# read and TXE#/WR write strobes into two ready/acknowledge "simple interface" streams for the FPGA core. It sits under the board wrapper, which owns the bidirectional pads (SB_IO primitives, OE-controlled). This block sees only split data buses plus an output-enable.

## Interface
- FT245_DATA_WIDTH, 8: width of the FT245 data bus.
- RX_WIDTH, 8: width of rx_data_si. Received bytes are zero-extended to this width.
- TX_WIDTH, 8: width of tx_data_si. Only the low FT245_DATA_WIDTH bits are transmitted.
- CLOCK_PERIOD_NS, 10.0: clk period, used to derive the strobe cycle counts.
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-high.
- rx_data_245, in, FT245_DATA_WIDTH: pad input data.
- rxf_245, in, 1: RXF#, active low, asynchronous; low means a byte is available.
- rx_245, out, 1: RD#, active low.
- tx_data_245, out, FT245_DATA_WIDTH: pad output data.
- txe_245, in, 1: TXE#, active low, asynchronous; low means there is space.
- wr_245, out, 1: WR, active high; the chip latches data on the falling edge.
- tx_oe_245, out, 1: pad output enable.
- rx_data_si, out, RX_WIDTH: received byte.
- rx_rdy_si, out, 1: rx_data_si is valid.
- rx_ack_si, in, 1: consumer takes the byte.
- tx_data_si, in, TX_WIDTH: byte to send.
- tx_rdy_si, in, 1: tx_data_si is valid.
- tx_ack_si, out, 1: one-cycle pulse; the byte has been accepted.

## Operation
- rxf_245 and txe_245 each pass through a 2-flop synchronizer: rxf_s, txe_s. rx_data_245 is sampled unsynchronized; it has been stable for ≥ T_ACT by the time it is sampled.
- Cycle counts: N(ns) = ceil(ns / CLOCK_PERIOD_NS), minimum 1.
  - ACT = N(60)
  - PRE = N(80)
  - SET = N(20)
- Reset values:
  - rx_245 = 1, wr_245 = 0, tx_oe_245 = 0
  - tx_data_245 = 0, rx_data_si = 0
  - rx_rdy_si = 0, tx_ack_si = 0
  - FSM in IDLE, last = TX
- Read request: rxf_s == 0 and rx buffer empty (rx_rdy_si == 0).
- Write request: txe_s == 0 and tx_rdy_si == 1.
- IDLE:
  - If both requests are pending, serve the one opposite to `last`.
  - Otherwise serve whichever request is pending.
- RD_ACT: rx_245 = 0 for ACT cycles. On the last cycle, register rx_data_245 into rx_data_si. Next state is RD_PRE.
- RD_PRE:
  - rx_245 = 1.
  - rx_rdy_si rises on entry.
  - Stay PRE cycles, then go to IDLE; last = RX.
- WR_SET:
  - Entry cycle: latch tx_data_si into tx_data_245, set tx_oe_245 = 1, pulse tx_ack_si for 1 cycle.
  - Hold SET cycles with wr_245 = 0, then go to WR_ACT.
- WR_ACT: wr_245 = 1 for ACT cycles. Next state is WR_HOLD.
- WR_HOLD: wr_245 = 0, data and OE still driven for 1 cycle. Next state is WR_PRE.
- WR_PRE: tx_oe_245 = 0 for PRE cycles, then go to IDLE; last = TX.
- rx buffer:
  - rx_rdy_si stays high and rx_data_si stays stable until a cycle with rx_ack_si = 1 while rx_rdy_si = 1. That clears rx_rdy_si on the next edge.
  - rx_ack_si while rx_rdy_si = 0 is ignored.
- rx_245 and wr_245 are never both active. tx_oe_245 is 0 whenever rx_245 = 0.
- rxf/txe changes during an active strobe are ignored until IDLE.
- rst mid-transaction aborts immediately to the reset values. rx_245 = 1 and tx_oe_245 = 0 on the next edge.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Input-edge-to-action latency: 2 sync cycles + 1 IDLE decision cycle. The strobe starts on the 3rd edge after the pin change.
- At CLOCK_PERIOD_NS = 10: ACT = 6, SET = 2, PRE = 8.
- Read cycle: 6 + 8 = 14 cycles, IDLE to IDLE. rx_rdy_si is high 7 cycles after RD# falls.
- Write cycle: 2 + 6 + 1 + 8 = 17 cycles. tx_ack_si pulses on the first WR_SET cycle.
- Back-to-back transactions: IDLE occupies 1 cycle between them.

## Structure
- Shared package ft245_pkg holds:
  - timing constants T_ACT_NS = 60, T_PRE_NS = 80, T_SET_NS = 20
  - the ns-to-cycles function
  - the state enum (IDLE, RD_ACT, RD_PRE, WR_SET, WR_ACT, WR_HOLD, WR_PRE)
- One natural sub-module: sync_2ff, used for rxf_245 and txe_245.
- Pad primitives (SB_IO) stay in the wrapper, not in this block.

## Test plan
- Reset: hold rst 3 cycles → rx_245 = 1, wr_245 = 0, tx_oe_245 = 0, rx_rdy_si = 0, tx_ack_si = 0.
- Single read:
  - Stimulus: rxf_245 = 0, rx_data_245 = 8'hA5, rx_ack_si held 0.
  - Response: rx_245 low exactly 6 cycles; rx_data_si = 8'hA5; rx_rdy_si stays high indefinitely, with no second RD# while rxf stays low.
  - Pulse rx_ack_si → rx_rdy_si drops, next read starts after PRE.
- Single write:
  - Stimulus: txe_245 = 0, tx_rdy_si = 1, tx_data_si = 8'h3C.
  - Response: tx_ack_si one pulse; tx_data_245 = 8'h3C with OE high ≥ 2 cycles before wr_245 rises; wr_245 high 6 cycles; OE high 1 cycle after the fall.
- Flow control: txe_245 = 1 with tx_rdy_si = 1 → no wr_245, no tx_ack_si. Releasing txe_245 starts the write 3 cycles later.
- Arbitration:
  - Stimulus: rxf and txe both low, tx_rdy_si = 1 continuously, rx_ack_si tied 1.
  - Response: transactions alternate RD, WR, RD, …; never overlapping; tx_oe_245 = 0 during every RD#.
- Reset mid-write: assert rst during WR_ACT → wr_245 = 0 and tx_oe_245 = 0 next edge; FSM in IDLE.
